rtc_timekeeper: RTL and testbench
=================================

// Module: rtc_timekeeper
// PURPOSE
//  Parametrised real-time clock: prescales clk to a 1 s tick; keeps sec/min/hour
//  (internal 24 h, 00:00:00..23:59:59); presents 12 h or 24 h view with PM flag.
//  Adds validated full-time load and a minute-resolution alarm with sticky pending flag.
//  Feeds display/alarm logic; one instance per board clock domain.
// PARAMETERS
//  CLK_DIV  50_000_000  clk cycles per second tick (>=2)
//  DIV_W    26          prescaler width; 2**DIV_W >= CLK_DIV
// PORTS
//  clk            in   1  clock
//  reset          in   1  synchronous, active-high reset
//  enable         in   1  1 = timekeeping runs; 0 = prescaler and time frozen
//  mode_24h       in   1  1 = 24 h view, 0 = 12 h view (display only)
//  set_time       in   1  1-cycle load strobe
//  set_sec        in   6  load value 0..59
//  set_min        in   6  load value 0..59
//  set_hour       in   5  load value 0..23 (always 24 h encoding)
//  alarm_en       in   1  alarm compare enable
//  alarm_min      in   6  alarm minute 0..59
//  alarm_hour     in   5  alarm hour 0..23 (24 h encoding)
//  alarm_ack      in   1  clears alarm_pending
//  sec            out  6  seconds 0..59
//  min            out  6  minutes 0..59
//  hour           out  5  24 h: 0..23; 12 h: 1..12
//  pm             out  1  1 when internal hour >= 12 (both modes)
//  sec_tick       out  1  1-cycle pulse per second
//  set_err        out  1  1-cycle pulse: rejected load
//  alarm_hit      out  1  1-cycle pulse on alarm match
//  alarm_pending  out  1  sticky alarm flag
// BEHAVIOUR
//  - Reset: prescaler, sec, min, internal hour = 0; sec_tick, set_err, alarm_hit,
//    alarm_pending = 0; pm = 0; hour reads 0 (24 h) or 12 (12 h).
//  - Prescaler counts 0..CLK_DIV-1 while enable=1; sec_tick=1 in the cycle count==CLK_DIV-1
//    (combinational); count wraps to 0; time advances at that edge.
//  - Carry chain in one edge: sec 59->0 carries min; min 59->0 carries hour; hour 23->0.
//    23:59:59 + tick -> 00:00:00 in one cycle. No value ever reads 60 or 24.
//  - enable=0: prescaler, time hold; sec_tick=0. Resumes from held prescaler count.
//  - set_time (priority over tick): all fields in range -> sec/min/hour loaded next edge,
//    prescaler cleared to 0, no tick that cycle. Any field out of range -> nothing changes,
//    set_err=1 next cycle. Load works regardless of enable.
//  - 12 h map (combinational, from internal h): h=0 -> 12; 1..12 -> h; 13..23 -> h-12.
//  - Alarm: when a tick-driven advance produces hour==alarm_hour, min==alarm_min, sec==0
//    and alarm_en=1, alarm_hit pulses the cycle after the advance and alarm_pending sets.
//    Loads via set_time never fire the alarm. alarm_en=0 suppresses hit; pending unchanged.
//  - alarm_ack clears pending next edge; ack and new hit same cycle -> pending stays 1.
//  - Reset mid-count: all state per reset list next edge; pending alarm lost.
// STRUCTURE
//  - rtc_pkg: SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, field widths 6/6/5, 12 h map function.
//  - Sub-module rtc_prescaler (CLK_DIV, DIV_W; enable, clear -> tick). Counters, load check,
//    12/24 h view, alarm in top.
// TESTING (CLK_DIV=4)
//  - Tick: enable=1 from reset -> sec_tick every 4th cycle; sec=1 after 4 cycles, 2 after 8.
//  - Rollover: load 23:59:59, wait one tick -> 00:00:00, pm 1->0; 12 h hour reads 12.
//  - 12 h view: load 13:05:00, mode_24h=0 -> hour=1, pm=1; mode_24h=1 -> hour=13.
//  - Bad load: set_sec=60 while at 10:00:00 -> set_err pulse, time unchanged, tick continues.
//  - Alarm: alarm 07:30, load 07:29:59 -> 1 tick -> alarm_hit 1 cycle, pending=1;
//    alarm_ack -> 0; ack concurrent with hit -> stays 1; load 07:30:00 -> no hit.
//  - Freeze/reset: enable=0 mid-count 3 s -> time holds; reset during count -> all 0.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared limits, field widths and the 24 h -> 12 h display mapping for the RTC.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

  // Midnight shows as 12, afternoon hours fold back by 12.
  function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
    if (h == 5'd0)
      return 5'd12;
    else if (h > 5'd12)
      return h - 5'd12;
    else
      return h;
  endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles; freezes when disabled.
module rtc_prescaler #(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIV_W   = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count;

  // A clear (time load) in the terminal cycle swallows that tick.
  assign tick = enable && !clear && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= (count == LAST) ? '0 : count + DIV_W'(1);
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time clock: sec/min/hour counters with validated load, 12/24 h view and a
// minute-resolution alarm with a sticky pending flag.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 50_000_000,
  parameter int DIV_W   = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode_24h,
  input  logic              set_time,
  input  logic [SEC_W-1:0]  set_sec,
  input  logic [MIN_W-1:0]  set_min,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic              alarm_en,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic              alarm_ack,
  output logic [SEC_W-1:0]  sec,
  output logic [MIN_W-1:0]  min,
  output logic [HOUR_W-1:0] hour,
  output logic              pm,
  output logic              sec_tick,
  output logic              set_err,
  output logic              alarm_hit,
  output logic              alarm_pending
);

  logic [SEC_W-1:0]  sec_q,  sec_n;
  logic [MIN_W-1:0]  min_q,  min_n;
  logic [HOUR_W-1:0] hour_q, hour_n;
  logic              load_ok;
  logic              tick;
  logic              alarm_match;

  assign load_ok = set_time && (set_sec <= SEC_MAX) && (set_min <= MIN_MAX)
                   && (set_hour <= HOUR_MAX);

  rtc_prescaler #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (load_ok),
    .tick   (tick)
  );

  // Time one second ahead, with the full carry chain resolved in a single step.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sec_n  = sec_q + 6'd1;
    min_n  = min_q;
    hour_n = hour_q;
    if (sec_q == SEC_MAX) begin
      sec_n = '0;
      if (min_q == MIN_MAX) begin
        min_n  = '0;
        hour_n = (hour_q == HOUR_MAX) ? '0 : hour_q + 5'd1;
      end else begin
        min_n = min_q + 6'd1;
      end
    end
  end

  assign alarm_match = alarm_en && (sec_n == '0) && (min_n == alarm_min)
                       && (hour_n == alarm_hour);

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_q         <= '0;
      min_q         <= '0;
      hour_q        <= '0;
      set_err       <= 1'b0;
      alarm_hit     <= 1'b0;
      alarm_pending <= 1'b0;
    end else begin
      set_err       <= set_time && !load_ok;
      alarm_hit     <= tick && alarm_match;
      // A fresh hit wins over a simultaneous acknowledge.
      alarm_pending <= (tick && alarm_match) || (alarm_pending && !alarm_ack);
      if (load_ok) begin
        sec_q  <= set_sec;
        min_q  <= set_min;
        hour_q <= set_hour;
      end else if (tick) begin
        sec_q  <= sec_n;
        min_q  <= min_n;
        hour_q <= hour_n;
      end
    end
  end

  assign sec      = sec_q;
  assign min      = min_q;
  assign hour     = mode_24h ? hour_q : to_12h(hour_q);
  assign pm       = (hour_q >= 5'd12);
  assign sec_tick = tick;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: directed scenarios plus random stimulus,
// compared every cycle against a seconds-of-day reference model.
module tb_rtc_timekeeper;

  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;
  localparam int DAY     = 86400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       mode_24h = 1'b1;
  logic       set_time = 1'b0;
  logic [5:0] set_sec = '0;
  logic [5:0] set_min = '0;
  logic [4:0] set_hour = '0;
  logic       alarm_en = 1'b0;
  logic [5:0] alarm_min = '0;
  logic [4:0] alarm_hour = '0;
  logic       alarm_ack = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       pm;
  logic       sec_tick;
  logic       set_err;
  logic       alarm_hit;
  logic       alarm_pending;

  int n_checks = 0;
  int n_errors = 0;

  rtc_timekeeper #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .mode_24h      (mode_24h),
    .set_time      (set_time),
    .set_sec       (set_sec),
    .set_min       (set_min),
    .set_hour      (set_hour),
    .alarm_en      (alarm_en),
    .alarm_min     (alarm_min),
    .alarm_hour    (alarm_hour),
    .alarm_ack     (alarm_ack),
    .sec           (sec),
    .min           (min),
    .hour          (hour),
    .pm            (pm),
    .sec_tick      (sec_tick),
    .set_err       (set_err),
    .alarm_hit     (alarm_hit),
    .alarm_pending (alarm_pending)
  );

  always #5 clk = ~clk;

  // Reference model: time as seconds since midnight, prescaler as a phase count.
  int tod   = 0;
  int phase = 0;
  bit m_err = 1'b0;
  bit m_hit = 1'b0;
  bit m_pend = 1'b0;

  function automatic bit valid_load();
    return set_time && (int'(set_sec) < 60) && (int'(set_min) < 60) && (int'(set_hour) < 24);
  endfunction

  always @(posedge clk) begin
    automatic bit ok  = valid_load();
    automatic bit tk  = enable && (phase == CLK_DIV - 1) && !ok;
    automatic bit hit = 1'b0;
    automatic int nt;
    if (reset) begin
      tod    <= 0;
      phase  <= 0;
      m_err  <= 1'b0;
      m_hit  <= 1'b0;
      m_pend <= 1'b0;
    end else begin
      if (ok) begin
        tod   <= int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
        phase <= 0;
      end else if (enable) begin
        phase <= (phase + 1) % CLK_DIV;
        if (tk) begin
          nt  = (tod + 1) % DAY;
          tod <= nt;
          hit = alarm_en && (nt == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
        end
      end
      m_err  <= set_time && !ok;
      m_hit  <= hit;
      m_pend <= hit || (m_pend && !alarm_ack);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    automatic int h   = tod / 3600;
    automatic int h12 = (h % 12 == 0) ? 12 : h % 12;
    check("sec",     32'(sec),           32'(tod % 60));
    check("min",     32'(min),           32'((tod / 60) % 60));
    check("hour",    32'(hour),          32'(mode_24h ? h : h12));
    check("pm",      32'(pm),            32'(h >= 12));
    check("tick",    32'(sec_tick),      32'(enable && phase == CLK_DIV - 1 && !valid_load()));
    check("set_err", 32'(set_err),       32'(m_err));
    check("hit",     32'(alarm_hit),     32'(m_hit));
    check("pending", 32'(alarm_pending), 32'(m_pend));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  task automatic load(input int h, input int m, input int s);
    set_time = 1'b1;
    set_hour = 5'(h);
    set_min  = 6'(m);
    set_sec  = 6'(s);
    step(1);
    set_time = 1'b0;
  endtask

  initial begin
    automatic logic [5:0] snap_s;
    automatic logic [5:0] snap_m;

    // Reset state in both views.
    @(posedge clk);
    #1;
    step(2);
    mode_24h = 1'b0;
    #1;
    check("rst_hour12", 32'(hour), 32'd12);
    mode_24h = 1'b1;
    reset = 1'b0;

    // Tick cadence from reset.
    enable = 1'b1;
    step(8);
    check("tick_sec2", 32'(sec), 32'd2);

    // Midnight rollover.
    load(23, 59, 59);
    step(3);
    check("roll_pm_before", 32'(pm), 32'd1);
    step(1);
    check("roll_hms", {11'd0, hour, min, sec}, 32'd0);
    check("roll_pm_after", 32'(pm), 32'd0);
    mode_24h = 1'b0;
    #1;
    check("roll_hour12", 32'(hour), 32'd12);

    // 12 h view of an afternoon hour.
    load(13, 5, 0);
    check("h12_hour", 32'(hour), 32'd1);
    check("h12_pm", 32'(pm), 32'd1);
    mode_24h = 1'b1;
    #1;
    check("h24_hour", 32'(hour), 32'd13);

    // Rejected load leaves time alone and keeps ticking.
    load(10, 0, 0);
    step(1);
    load(10, 0, 60);
    check("bad_err", 32'(set_err), 32'd1);
    check("bad_hms", {11'd0, hour, min, sec}, {11'd0, 5'd10, 6'd0, 6'd0});
    step(6);
    load(24, 0, 0);
    step(2);

    // Alarm hit, ack, ack concurrent with hit, load never fires.
    alarm_en   = 1'b1;
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    load(7, 29, 59);
    step(3);
    step(1);
    check("alarm_hit", 32'(alarm_hit), 32'd1);
    check("alarm_pend", 32'(alarm_pending), 32'd1);
    step(1);
    alarm_ack = 1'b1;
    load(7, 29, 59);
    step(3);
    check("ack_clears", 32'(alarm_pending), 32'd0);
    step(1);
    check("ack_vs_hit", 32'(alarm_pending), 32'd1);
    alarm_ack = 1'b0;
    step(1);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    load(7, 30, 0);
    step(8);
    check("load_no_pend", 32'(alarm_pending), 32'd0);
    alarm_en = 1'b0;
    load(7, 29, 59);
    step(5);

    // Freeze mid-count, then reset mid-count with an alarm pending.
    load(1, 2, 3);
    step(14);
    enable = 1'b0;
    snap_s = sec;
    snap_m = min;
    step(10);
    check("freeze_sec", 32'(sec), 32'(snap_s));
    check("freeze_min", 32'(min), 32'(snap_m));
    enable   = 1'b1;
    step(6);
    alarm_en = 1'b1;
    load(7, 29, 59);
    step(6);
    reset = 1'b1;
    step(1);
    check("rst_pend", 32'(alarm_pending), 32'd0);
    reset = 1'b0;
    step(5);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      mode_24h  = 1'($urandom_range(0, 1));
      alarm_ack = ($urandom_range(0, 7) == 0);
      alarm_en  = ($urandom_range(0, 9) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      set_time  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) begin
        set_hour = 5'($urandom_range(0, 31));
        set_min  = 6'($urandom_range(0, 63));
        set_sec  = 6'($urandom_range(0, 63));
      end else begin
        set_hour = 5'($urandom_range(0, 23));
        set_min  = 6'($urandom_range(0, 59));
        set_sec  = $urandom_range(0, 1) ? 6'd59 : 6'($urandom_range(0, 59));
      end
      if (set_time && $urandom_range(0, 1) && set_min < 6'd59 && set_hour < 5'd24) begin
        alarm_hour = set_hour;
        alarm_min  = set_min + 6'd1;
      end
      step(1);
    end
    reset    = 1'b0;
    set_time = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
